// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC selection and the IF/ID register.
// Optional performance counters (fetch_cnt, bubble_cnt) are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_plus4;
    logic        load_valid;
    logic        load_bubble;

    assign pc_plus4 = pc_q + 32'd4;

    // Priority: stall holds everything, jump beats branch, otherwise sequential fetch.
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        load_valid  = 1'b0;
        load_bubble = 1'b0;
        if (stall) begin
            load_bubble = 1'b1;
        end else if (jump) begin
            pc_d        = {jump_target[31:2], 2'b00};
            instr_d     = 32'h0;
            pc4_d       = 32'h0;
            valid_d     = 1'b0;
            load_bubble = 1'b1;
        end else if (branch_taken) begin
            pc_d        = {branch_target[31:2], 2'b00};
            instr_d     = 32'h0;
            pc4_d       = 32'h0;
            valid_d     = 1'b0;
            load_bubble = 1'b1;
        end else begin
            pc_d       = pc_plus4;
            instr_d    = imem_rdata;
            pc4_d      = pc_plus4;
            valid_d    = 1'b1;
            load_valid = 1'b1;
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= PC_RESET;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (load_valid)  fetch_cnt_d  = fetch_cnt_q + 32'd1;
        if (load_bubble) bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = load_valid ^ load_bubble;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a cycle-level reference model checked on every
// falling edge, plus directed literal checks following the test plan.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    int errors = 0;
    int checks = 0;

    fetch_stage #(.PC_RESET(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt     (fetch_cnt),
        .bubble_cnt    (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h2000_0000 | addr;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: architectural view of PC and the IF/ID slot.
    logic [31:0] m_pc, m_instr, m_pc4, m_fetch, m_bubble;
    logic        m_valid;
    bit          m_known = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_fetch = 32'h0; m_bubble = 32'h0;
            m_known = 1;
        end else if (m_known) begin
            if (stall) begin
                m_bubble = m_bubble + 1;
            end else if (jump || branch_taken) begin
                m_pc = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
                m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
                m_bubble = m_bubble + 1;
            end else begin
                m_instr = mem_word(m_pc);
                m_pc = m_pc + 32'd4;
                m_pc4 = m_pc;
                m_valid = 1'b1;
                m_fetch = m_fetch + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            check("model_imem_addr", imem_addr, m_pc);
            check("model_instr", if_id_instr, m_instr);
            check("model_pc4", if_id_pc4, m_pc4);
            check("model_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
`ifdef FETCH_PERF_CNT_EN
            check("model_fetch_cnt", fetch_cnt, m_fetch);
            check("model_bubble_cnt", bubble_cnt, m_bubble);
`endif
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                                input logic [31:0] pc4, input logic valid);
        check({tag, "_addr"}, imem_addr, addr);
        check({tag, "_instr"}, if_id_instr, instr);
        check({tag, "_pc4"}, if_id_pc4, pc4);
        check({tag, "_valid"}, {31'h0, if_id_valid}, {31'h0, valid});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0;

        // Reset then free-run
        cycle(); cycle();
        expect_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        cycle();
        expect_state("run1", 32'h4, 32'h2000_0000, 32'h4, 1'b1);
        cycle();
        expect_state("run2", 32'h8, 32'h2000_0004, 32'h8, 1'b1);
        cycle(); cycle();
        check("at_0x10", imem_addr, 32'h10);

        // Stall 3 cycles at PC = 0x10
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            expect_state("stall", 32'h10, 32'h2000_000C, 32'h10, 1'b1);
        end
        stall = 1'b0;
        cycle();
        expect_state("post_stall", 32'h14, 32'h2000_0010, 32'h14, 1'b1);

        // Branch taken at PC = 0x20
        cycle(); cycle(); cycle();
        check("at_0x20", imem_addr, 32'h20);
        branch_taken = 1'b1; branch_target = 32'h40;
        cycle();
        expect_state("branch", 32'h40, 32'h0, 32'h0, 1'b0);
        branch_taken = 1'b0;
        cycle();
        expect_state("branch_tgt", 32'h44, 32'h2000_0040, 32'h44, 1'b1);

        // Jump and branch together; then the same with stall
        jump = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h200;
        cycle();
        expect_state("jump_wins", 32'h100, 32'h0, 32'h0, 1'b0);
        stall = 1'b1;
        cycle();
        expect_state("stall_redirect", 32'h100, 32'h0, 32'h0, 1'b0);
        stall = 1'b0; branch_taken = 1'b0;

        // Misaligned target, then wrap
        jump_target = 32'h37;
        cycle();
        check("misaligned", imem_addr, 32'h34);
        jump_target = 32'hFFFF_FFFC;
        cycle();
        check("at_top", imem_addr, 32'hFFFF_FFFC);
        jump = 1'b0;
        cycle();
        expect_state("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);

        // Reset, then 5 fetches, 1 redirect, 2 stalls
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        branch_taken = 1'b1; branch_target = 32'h80;
        cycle();
        branch_taken = 1'b0; stall = 1'b1;
        cycle(); cycle();
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt", fetch_cnt, 32'd5);
        check("bubble_cnt", bubble_cnt, 32'd3);
`endif
        check("pre_reset_addr", imem_addr, 32'h80);

        // Reset mid-stall with a pending redirect
        reset = 1'b1; jump = 1'b1; jump_target = 32'h300;
        cycle();
        expect_state("reset_mid_stall", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt_rst", fetch_cnt, 32'd0);
        check("bubble_cnt_rst", bubble_cnt, 32'd0);
`endif
        reset = 1'b0; stall = 1'b0; jump = 1'b0;
        cycle();
        expect_state("after_reset", 32'h4, 32'h2000_0000, 32'h4, 1'b1);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
